// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions.
// Stage register state encoding and level width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_LEVEL_W = 2;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with one-entry skid buffer.
// in_ready comes straight from the state register.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [PIPE_LEVEL_W-1:0] level
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;
  assign out_data = main_q;

  // Handshake flags and occupancy decoded from state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    level     = '0;
    unique case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        level     = 2'd0;
      end
      BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        level     = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        level     = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        level     = 2'd0;
      end
    endcase
  end

  // Next state and register loads; data held unless a transfer occurs.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg.
// Directed vectors plus random traffic against a queue model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  level1;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  level0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  logic        mon_en     = 1'b0;
  logic        post_flush = 1'b0;
  logic [31:0] held0      = '0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .level(level1)
  );

  pipe_skid_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .level(level0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] id,
                      input logic ordy, input logic st,
                      input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT state to the model, then advance the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid1", {31'b0, out_valid1}, {31'b0, q.size() != 0});
      chk("valid0", {31'b0, out_valid0}, {31'b0, q.size() != 0});
      chk("level1", {30'b0, level1}, q.size());
      chk("level0", {30'b0, level0}, q.size());
      chk("ready1", {31'b0, in_ready1}, {31'b0, q.size() < 2});
      chk("ready0", {31'b0, in_ready0}, {31'b0, q.size() < 2});
      if (q.size() != 0) begin
        chk("data1", out_data1, q[0]);
        chk("data0", out_data0, q[0]);
      end
      if (post_flush) begin
        chk("flush_clr1", out_data1, 32'h0);
        chk("flush_keep0", out_data0, held0);
      end
    end
    post_flush = 1'b0;
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
      post_flush = 1'b1;
      held0 = out_data0;
    end else begin
      logic m_in, m_out;
      m_in  = in_valid && (q.size() < 2);
      m_out = (q.size() != 0) && out_ready && !stall;
      if (m_out) void'(q.pop_front());
      if (m_in) q.push_back(in_data);
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1, 32'hDEADBEEF, 0, 0, 0);
    chk("rst_valid", {31'b0, out_valid1}, 32'd0);
    chk("rst_data1", out_data1, 32'd0);
    chk("rst_data0", out_data0, 32'd0);
    chk("rst_level", {30'b0, level1}, 32'd0);
    chk("rst_ready", {31'b0, in_ready1}, 32'd1);
    rst_n = 1'b1;

    step(1, 32'h1, 1, 0, 0);
    chk("st1_data", out_data1, 32'h1);
    chk("st1_level", {30'b0, level1}, 32'd1);
    step(1, 32'h2, 1, 0, 0);
    chk("st2_data", out_data1, 32'h2);
    chk("st2_ready", {31'b0, in_ready1}, 32'd1);
    step(1, 32'h3, 1, 0, 0);
    chk("st3_data", out_data1, 32'h3);
    chk("st3_level", {30'b0, level1}, 32'd1);
    step(0, 32'h0, 1, 0, 0);
    chk("st_empty", {31'b0, out_valid1}, 32'd0);

    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    chk("bp_level", {30'b0, level1}, 32'd2);
    chk("bp_ready", {31'b0, in_ready1}, 32'd0);
    chk("bp_data", out_data1, 32'hA);
    step(0, 32'h0, 0, 0, 0);
    chk("bp_stable", out_data1, 32'hA);
    step(0, 32'h0, 1, 0, 0);
    chk("bp_drainA", out_data1, 32'hB);
    chk("bp_ready1", {31'b0, in_ready1}, 32'd1);
    step(0, 32'h0, 1, 0, 0);
    chk("bp_drainB", {31'b0, out_valid1}, 32'd0);

    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'h55, 0, 0, 1);
    chk("fl_level1", {30'b0, level1}, 32'd0);
    chk("fl_valid1", {31'b0, out_valid1}, 32'd0);
    chk("fl_data1", out_data1, 32'd0);
    chk("fl_valid0", {31'b0, out_valid0}, 32'd0);
    chk("fl_data0", out_data0, 32'hA);
    step(0, 32'h0, 0, 0, 0);
    chk("fl_no55", {30'b0, level1}, 32'd0);

    step(1, 32'h7, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 1, 1, 0);
      chk("stall_data", out_data1, 32'h7);
      chk("stall_valid", {31'b0, out_valid1}, 32'd1);
    end
    step(0, 32'h0, 1, 0, 0);
    chk("stall_xfer", {31'b0, out_valid1}, 32'd0);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 99) < 30, $urandom,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30);
    end
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
